// File: rtl/eq_coeff_scheduler.sv
// Coefficient-load scheduler for the 8-band equalizer: round-robin grant, coefficient streaming, phase-0 aligned swap.
// Optional running checksum of loaded coefficients is enabled by defining EQ_COEFF_CHECKSUM_EN.
module eq_coeff_scheduler #(
  parameter int NUM_BANDS = 8,
  parameter int NUM_TAPS  = 64,
  parameter int COEFF_W   = 16,
  parameter int ADDR_W    = 6,
  localparam int BAND_W   = $clog2(NUM_BANDS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_enable,
  input  logic                      i_phase_0,
  input  logic [NUM_BANDS-1:0]      i_load_req,
  output logic [NUM_BANDS-1:0]      o_load_ack,
  output logic                      o_busy,
  output logic                      o_coeff_rd_en,
  output logic [BAND_W-1:0]         o_coeff_rd_band,
  output logic [ADDR_W-1:0]         o_coeff_rd_addr,
  input  logic signed [COEFF_W-1:0] i_coeff_rd_data,
  output logic [NUM_BANDS-1:0]      o_write_enable,
  output logic [ADDR_W-1:0]         o_write_address,
  output logic signed [COEFF_W-1:0] o_coeffs_out,
  output logic [NUM_BANDS-1:0]      o_write_done,
  output logic signed [COEFF_W-1:0] o_checksum
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_STREAM, S_DRAIN, S_WAIT_PH0, S_DONE, S_ACK
  } state_t;

  state_t                 state, state_nxt;
  logic [BAND_W-1:0]      band_g;
  logic [BAND_W-1:0]      rr_ptr;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   vld_p1;
  logic [ADDR_W-1:0]      wr_addr_p1;
  logic                   pick_vld;
  logic [BAND_W-1:0]      pick_band;
  logic [NUM_BANDS-1:0]   band_oh;

  // Scans downward so the band closest to the pointer is the one left standing.
  function automatic logic [BAND_W:0] rr_pick(input logic [NUM_BANDS-1:0] req,
                                              input logic [BAND_W-1:0]    ptr);
    logic [BAND_W:0]   res;
    logic [BAND_W-1:0] idx;
    res = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      idx = ptr + BAND_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {pick_vld, pick_band} = rr_pick(i_load_req, rr_ptr);
  assign band_oh = {{(NUM_BANDS-1){1'b0}}, 1'b1} << band_g;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else if (clk_enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (|i_load_req) state_nxt = S_GRANT;
      S_GRANT:    state_nxt = pick_vld ? S_STREAM : S_IDLE;
      S_STREAM:   if (rd_addr == LAST_TAP) state_nxt = S_DRAIN;
      S_DRAIN:    state_nxt = S_WAIT_PH0;
      S_WAIT_PH0: if (i_phase_0) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_ACK;
      S_ACK:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: read request; stage p1: filter write one enabled cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      band_g     <= '0;
      rr_ptr     <= '0;
      rd_addr    <= '0;
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
    end else if (clk_enable) begin
      if (state == S_GRANT) begin
        band_g  <= pick_band;
        rd_addr <= '0;
      end
      if (state == S_STREAM && rd_addr != LAST_TAP) rd_addr <= rd_addr + 1'b1;
      vld_p1     <= (state == S_STREAM);
      wr_addr_p1 <= rd_addr;
      if (state == S_ACK) rr_ptr <= band_g + 1'b1;
    end
  end

`ifdef EQ_COEFF_CHECKSUM_EN
  logic signed [COEFF_W-1:0] acc_p1;
  logic signed [COEFF_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p1     <= '0;
      checksum_q <= '0;
    end else if (clk_enable) begin
      if (state == S_GRANT) acc_p1 <= '0;
      else if (vld_p1) acc_p1 <= acc_p1 + i_coeff_rd_data;
      if (state == S_WAIT_PH0 && i_phase_0) checksum_q <= acc_p1;
    end
  end

  assign o_checksum = checksum_q;
`else
  assign o_checksum = '0;
`endif

  always_comb begin
    o_busy          = (state != S_IDLE);
    o_coeff_rd_en   = 1'b0;
    o_coeff_rd_band = '0;
    o_coeff_rd_addr = '0;
    o_write_enable  = '0;
    o_write_address = '0;
    o_coeffs_out    = '0;
    o_write_done    = '0;
    o_load_ack      = '0;
    if (state == S_STREAM) begin
      o_coeff_rd_en   = 1'b1;
      o_coeff_rd_band = band_g;
      o_coeff_rd_addr = rd_addr;
    end
    if (vld_p1) begin
      o_write_enable  = band_oh;
      o_write_address = wr_addr_p1;
      o_coeffs_out    = i_coeff_rd_data;
    end
    if (state == S_DONE) o_write_done = band_oh;
    if (state == S_ACK) o_load_ack = band_oh;
  end

endmodule

// File: tb/tb_eq_coeff_scheduler.sv
// Self-checking bench for eq_coeff_scheduler: timeline reference model, directed literal checks, random traffic.
module tb_eq_coeff_scheduler;
  localparam int NB = 8;
  localparam int NT = 64;
  localparam int CW = 16;
  localparam int AW = 6;
`ifdef EQ_COEFF_CHECKSUM_EN
  localparam logic [CW-1:0] EXP_CS_7FFF = 16'hFFC0;
`else
  localparam logic [CW-1:0] EXP_CS_7FFF = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_enable = 1'b1;
  logic          i_phase_0 = 1'b0;
  logic [NB-1:0] i_load_req = '0;
  logic [CW-1:0] i_coeff_rd_data = '0;
  logic [NB-1:0] o_load_ack, o_write_enable, o_write_done;
  logic          o_busy, o_coeff_rd_en;
  logic [2:0]    o_coeff_rd_band;
  logic [AW-1:0] o_coeff_rd_addr, o_write_address;
  logic [CW-1:0] o_coeffs_out, o_checksum;

  eq_coeff_scheduler dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .i_phase_0(i_phase_0),
    .i_load_req(i_load_req), .o_load_ack(o_load_ack), .o_busy(o_busy),
    .o_coeff_rd_en(o_coeff_rd_en), .o_coeff_rd_band(o_coeff_rd_band),
    .o_coeff_rd_addr(o_coeff_rd_addr), .i_coeff_rd_data(i_coeff_rd_data),
    .o_write_enable(o_write_enable), .o_write_address(o_write_address),
    .o_coeffs_out(o_coeffs_out), .o_write_done(o_write_done), .o_checksum(o_checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int data_mode = 0;
  int unsigned seed_k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] store_val(input int band, input int addr);
    case (data_mode)
      0:       return CW'(addr * 3);
      1:       return 16'h7FFF;
      default: return CW'((band * 1237 + addr * 911) ^ seed_k);
    endcase
  endfunction

  function automatic logic [CW-1:0] load_sum(input int band);
    logic [CW-1:0] s = '0;
    for (int k = 0; k < NT; k++) s = s + store_val(band, k);
    return s;
  endfunction

  function automatic int rr_pick(input logic [NB-1:0] req, input int ptr);
    for (int i = 0; i < NB; i++) if (req[(ptr + i) % NB]) return (ptr + i) % NB;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NB-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Coefficient store: registered read, advances only on enabled edges.
  initial begin : store
    logic pend;
    logic [2:0] pb;
    logic [AW-1:0] pa;
    forever begin
      @(negedge clk);
      pend = o_coeff_rd_en; pb = o_coeff_rd_band; pa = o_coeff_rd_addr;
      @(posedge clk);
      if (clk_enable && rst && pend) begin
        #1 i_coeff_rd_data = store_val(int'(pb), int'(pa));
      end
    end
  end

  // Reference model: position of the current enabled cycle within a load timeline.
  // e=0 idle cycle that saw a request, 1 grant, 2..NT+1 reads, 3..NT+2 writes, then wait/done/ack.
  bit            m_active;
  int            m_e, m_done_at, m_g, m_ptr;
  logic [CW-1:0] m_cs;

  task automatic m_reset();
    m_active = 0; m_e = 0; m_done_at = 0; m_g = 0; m_ptr = 0; m_cs = '0;
  endtask

  task automatic m_step();
    if (!m_active) begin
      if (i_load_req != 0) begin m_active = 1; m_e = 1; m_done_at = 0; end
      return;
    end
    if (m_e == 1) begin
      m_g = rr_pick(i_load_req, m_ptr);
      if (m_g < 0) begin m_active = 0; m_e = 0; m_g = 0; return; end
    end
    if (m_done_at != 0 && m_e == m_done_at + 1) begin
      m_active = 0; m_e = 0; m_ptr = (m_g + 1) % NB;
      return;
    end
    if (m_e >= NT + 3 && m_done_at == 0 && i_phase_0) begin
      m_done_at = m_e + 1;
      m_cs = load_sum(m_g);
    end
    m_e++;
  endtask

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else if (clk_enable) m_step();
    end
  end

  initial begin : compare
    logic          e_busy, e_rden;
    logic [NB-1:0] e_we, e_done, e_ack, oh;
    logic [CW-1:0] e_cs;
    forever begin
      @(negedge clk);
      oh     = NB'(1) << m_g;
      e_busy = m_active;
      e_rden = m_active && m_e >= 2 && m_e <= NT + 1;
      e_we   = (m_active && m_e >= 3 && m_e <= NT + 2) ? oh : '0;
      e_done = (m_active && m_done_at != 0 && m_e == m_done_at) ? oh : '0;
      e_ack  = (m_active && m_done_at != 0 && m_e == m_done_at + 1) ? oh : '0;
`ifdef EQ_COEFF_CHECKSUM_EN
      e_cs = m_cs;
`else
      e_cs = '0;
`endif
      chk("ctrl", {o_busy, o_coeff_rd_en, o_write_enable, o_write_done, o_load_ack},
          {e_busy, e_rden, e_we, e_done, e_ack});
      if (e_rden) chk("rd_sel", {o_coeff_rd_band, o_coeff_rd_addr}, {3'(m_g), AW'(m_e - 2)});
      if (e_we != 0)
        chk("wr_data", {o_write_address, o_coeffs_out}, {AW'(m_e - 3), store_val(m_g, m_e - 3)});
      chk("checksum", o_checksum, e_cs);
    end
  end

  // Event monitor in enabled-cycle time, feeding the directed literal checks.
  int            ecyc = 0, wr_cnt = 0, last_wr_cyc = -1, done_cyc = -1;
  logic [CW-1:0] last_data = '0, done_cs = '0;
  int            ack_q[$];

  initial begin : monitor
    logic [NB-1:0] c_we, c_done, c_ack;
    logic [AW-1:0] c_addr;
    logic [CW-1:0] c_data, c_cs;
    forever begin
      @(negedge clk);
      c_we = o_write_enable; c_done = o_write_done; c_ack = o_load_ack;
      c_addr = o_write_address; c_data = o_coeffs_out; c_cs = o_checksum;
      @(posedge clk);
      if (rst && clk_enable) begin
        ecyc++;
        if (c_we != 0) begin
          wr_cnt++;
          if (int'(c_addr) == NT - 1) begin last_wr_cyc = ecyc; last_data = c_data; end
        end
        if (c_done != 0) begin done_cyc = ecyc; done_cs = c_cs; end
        if (c_ack != 0) ack_q.push_back(onehot_idx(c_ack));
      end
    end
  end

  function automatic int ack_at(input int i);
    return (i < ack_q.size()) ? ack_q[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_for(input int what, input int arg, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      case (what)
        0:       ok = o_coeff_rd_en;
        1:       ok = (ack_q.size() >= arg);
        2:       ok = (last_wr_cyc >= 0);
        3:       ok = !o_busy;
        default: ok = o_coeff_rd_en && (int'(o_coeff_rd_addr) == arg);
      endcase
    end
    chk(name, ok, 1);
  endtask

  task automatic clear_mon();
    wr_cnt = 0; last_wr_cyc = -1; done_cyc = -1; ack_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    tick(3);
    chk("reset_outs", {o_busy, o_coeff_rd_en, o_write_enable, o_write_done, o_load_ack,
                       o_write_address, o_coeffs_out, o_checksum}, '0);
    rst = 1'b1;
    tick(3);
    chk("idle_busy", o_busy, 0);

    // Single load of band 2, data = 3*addr, phase_0 five cycles after the last write.
    clear_mon();
    i_load_req = 8'h04;
    wait_for(0, 0, 20, "t2_wait_read");
    i_load_req = '0;
    wait_for(2, 0, 200, "t2_wait_last_write");
    tick(4);
    i_phase_0 = 1'b1;
    tick(1);
    i_phase_0 = 1'b0;
    wait_for(1, 1, 40, "t2_wait_ack");
    chk("t2_write_count", wr_cnt, 64);
    chk("t2_last_data", last_data, 189);
    chk("t2_ack_band", ack_at(0), 2);
    chk("t2_done_gap", done_cyc - last_wr_cyc, 6);

    // phase_0 already high on the first wait cycle: no extra wait.
    clear_mon();
    i_phase_0 = 1'b1;
    i_load_req = 8'h40;
    wait_for(0, 0, 20, "t4_wait_read");
    i_load_req = '0;
    wait_for(1, 1, 200, "t4_wait_ack");
    chk("t4_done_gap", done_cyc - last_wr_cyc, 2);
    chk("t4_ack_band", ack_at(0), 6);

    // Asynchronous reset in the middle of streaming band 3.
    i_load_req = 8'h08;
    wait_for(4, 10, 100, "t1_wait_stream");
    #1 rst = 1'b0;
    #1 chk("t1_abort_outs", {o_busy, o_coeff_rd_en, o_write_enable, o_write_done, o_load_ack,
                             o_coeffs_out, o_checksum}, '0);
    i_load_req = '0;
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("t1_idle_after", {o_busy, o_coeff_rd_en}, 0);

    // Round robin with every band requesting.
    clear_mon();
    i_load_req = 8'hFF;
    wait_for(1, 9, 1200, "t3_wait_acks");
    for (int i = 0; i < 9; i++) chk($sformatf("t3_ack_order_%0d", i), ack_at(i), i % NB);
    i_load_req = '0;
    wait_for(3, 0, 200, "t3_wait_idle");

    // clk_enable toggling during a load of band 5.
    clear_mon();
    i_load_req = 8'h20;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      clk_enable = ~clk_enable;
      tick(1);
      if (o_coeff_rd_en) i_load_req = '0;
      ok = (ack_q.size() >= 1);
    end
    clk_enable = 1'b1;
    chk("t5_wait_ack", ok, 1);
    chk("t5_write_count", wr_cnt, 64);
    chk("t5_last_data", last_data, 189);
    chk("t5_ack_band", ack_at(0), 5);
    tick(3);

    // Checksum with all-0x7FFF coefficients.
    clear_mon();
    data_mode = 1;
    i_load_req = 8'h01;
    wait_for(0, 0, 20, "t6_wait_read");
    i_load_req = '0;
    wait_for(1, 1, 200, "t6_wait_ack");
    chk("t6_checksum_at_done", done_cs, EXP_CS_7FFF);
    tick(2);
    chk("t6_checksum_hold", o_checksum, EXP_CS_7FFF);

    // Randomized traffic against the reference model.
    data_mode = 2;
    seed_k = $urandom;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) i_load_req = NB'($urandom_range(0, 255));
      i_phase_0  = ($urandom_range(0, 2) == 0);
      clk_enable = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    i_load_req = '0;
    clk_enable = 1'b1;
    i_phase_0  = 1'b1;
    wait_for(3, 0, 300, "rand_wait_idle");
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
